ps2_host_tx: RTL and testbench



---
 rtl/ps2_pkg.sv | 30 +++
 rtl/ps2_line_filter.sv | 42 ++++
 rtl/ps2_host_tx.sv | 170 +++++++++++++++++
 tb/tb_ps2_host_tx.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter states, frame layout and timing helpers
// used by both the host transmitter and the keyboard receiver.
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      REQ,
      SEND,
      ACK,
      WAIT_IDLE
   } ps2_state_t;

   localparam int FRAME_BITS = 11;               // start, 8 data, odd parity, stop
   localparam int DATA_BITS  = 8;
   localparam int SHIFT_BITS = FRAME_BITS - 1;   // bits clocked out after the start bit

   function automatic int inhibit_cycles(input int clk_hz, input int us);
      return clk_hz / 1_000_000 * us;
   endfunction

   function automatic int timeout_cycles(input int clk_hz, input int ms);
      return clk_hz / 1000 * ms;
   endfunction

   function automatic logic odd_parity(input logic [DATA_BITS-1:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser and stability filter for an open-drain PS/2 line, with a
// one-cycle pulse on the selected edge of the filtered value.
module ps2_line_filter #(
   parameter int FILTER_LEN  = 8,
   parameter bit DETECT_FALL = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic pin,
   output logic filt,
   output logic edge_pulse
);

   localparam int CW = $clog2(FILTER_LEN + 1);
   localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);

   logic [1:0]    sync_q;
   logic [CW-1:0] stable_cnt;

   // Idle bus is pulled high, so the synchroniser and filter come out of reset at 1.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q     <= 2'b11;
         stable_cnt <= '0;
         filt       <= 1'b1;
         edge_pulse <= 1'b0;
      end else begin
         sync_q     <= {sync_q[0], pin};
         edge_pulse <= 1'b0;
         if (sync_q[1] == filt) begin
            stable_cnt <= '0;
         end else if (stable_cnt == LAST) begin
            stable_cnt <= '0;
            filt       <= sync_q[1];
            edge_pulse <= DETECT_FALL ? filt : ~filt;
         end else begin
            stable_cnt <= stable_cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter; drives the shared PS2_CLK/PS2_DATA pins
// through open-drain enables and reports completion or failure with tx_done/tx_err.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | lines released, ready for a command byte
// INHIBIT   | hold clock low to request a host-to-device transfer
// REQ       | one cycle with clock and data low (start bit)
// SEND      | clock released; shift data, parity, stop on each device clock fall
// ACK       | data released; sample the device acknowledge on the next fall
// WAIT_IDLE | wait for clock and data both high, then report
import ps2_pkg::*;

module ps2_host_tx #(
   parameter int CLK_FREQUENCY_HZ = 50_000_000,
   parameter int INHIBIT_US       = 100,
   parameter int TIMEOUT_MS       = 20,
   parameter int FILTER_LEN       = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       busy,
   output logic       tx_done,
   output logic       tx_err,
   input  logic       kclk_in,
   input  logic       kdata_in,
   output logic       kclk_oe,
   output logic       kdata_oe
);

   localparam int INHIBIT_CYC = inhibit_cycles(CLK_FREQUENCY_HZ, INHIBIT_US);
   localparam int TIMEOUT_CYC = timeout_cycles(CLK_FREQUENCY_HZ, TIMEOUT_MS);
   localparam int IW          = (INHIBIT_CYC > 1) ? $clog2(INHIBIT_CYC) : 1;
   localparam int TW          = $clog2(TIMEOUT_CYC + 1);
   localparam logic [3:0] LAST_IDX = 4'(FRAME_BITS - 1);

   ps2_state_t            state;
   logic [SHIFT_BITS-1:0] shreg;
   logic [3:0]            idx;
   logic [IW-1:0]         inh_cnt;
   logic [TW-1:0]         tmo_cnt;
   logic                  nack;
   logic [1:0]            kdata_sync_q;
   logic                  kdata_sync;
   logic                  kclk_filt;
   logic                  kclk_fall;
   logic                  tmo_hit;

   ps2_line_filter #(
      .FILTER_LEN  (FILTER_LEN),
      .DETECT_FALL (1'b1)
   ) u_kclk_filter (
      .clk        (clk),
      .reset      (reset),
      .pin        (kclk_in),
      .filt       (kclk_filt),
      .edge_pulse (kclk_fall)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         kdata_sync_q <= 2'b11;
      end else begin
         kdata_sync_q <= {kdata_sync_q[0], kdata_in};
      end
   end

   assign kdata_sync = kdata_sync_q[1];
   assign tmo_hit    = (tmo_cnt == TW'(1));
   assign busy       = (state != IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         shreg    <= '0;
         idx      <= '0;
         inh_cnt  <= '0;
         tmo_cnt  <= '0;
         nack     <= 1'b0;
         kclk_oe  <= 1'b0;
         kdata_oe <= 1'b0;
         tx_ready <= 1'b1;
         tx_done  <= 1'b0;
         tx_err   <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         tx_err  <= 1'b0;
         unique case (state)
            IDLE: begin
               kclk_oe  <= 1'b0;
               kdata_oe <= 1'b0;
               tx_ready <= 1'b1;
               if (tx_valid && tx_ready) begin
                  shreg    <= {1'b1, odd_parity(tx_data), tx_data};
                  idx      <= '0;
                  nack     <= 1'b0;
                  inh_cnt  <= IW'(INHIBIT_CYC - 1);
                  kclk_oe  <= 1'b1;
                  tx_ready <= 1'b0;
                  state    <= INHIBIT;
               end
            end
            INHIBIT: begin
               if (inh_cnt == '0) begin
                  kdata_oe <= 1'b1;
                  state    <= REQ;
               end else begin
                  inh_cnt <= inh_cnt - IW'(1);
               end
            end
            REQ: begin
               kclk_oe <= 1'b0;
               tmo_cnt <= TW'(TIMEOUT_CYC);
               state   <= SEND;
            end
            SEND, ACK, WAIT_IDLE: begin
               // Timeout is checked first so it wins over a coincident clock fall.
               if (tmo_hit) begin
                  tmo_cnt  <= '0;
                  kclk_oe  <= 1'b0;
                  kdata_oe <= 1'b0;
                  tx_done  <= 1'b1;
                  tx_err   <= 1'b1;
                  state    <= IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt - TW'(1);
                  case (state)
                     SEND: begin
                        if (kclk_fall) begin
                           if (idx == LAST_IDX) begin
                              kdata_oe <= 1'b0;
                              state    <= ACK;
                           end else begin
                              kdata_oe <= ~shreg[0];
                              shreg    <= {1'b1, shreg[SHIFT_BITS-1:1]};
                              idx      <= idx + 4'd1;
                           end
                        end
                     end
                     ACK: begin
                        kdata_oe <= 1'b0;
                        if (kclk_fall) begin
                           nack  <= kdata_sync;
                           state <= WAIT_IDLE;
                        end
                     end
                     default: begin
                        if (kclk_filt && kdata_sync) begin
                           tmo_cnt <= '0;
                           tx_done <= 1'b1;
                           tx_err  <= nack;
                           state   <= IDLE;
                        end
                     end
                  endcase
               end
            end
            default: begin
               kclk_oe  <= 1'b0;
               kdata_oe <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx with an open-drain bus model and a simple PS/2 device.
// The DUT runs with a 2 MHz nominal clock so inhibit is 200 cycles and timeout 2000.
module tb_ps2_host_tx;

   localparam int HALF        = 50;     // device clock half period in clk cycles
   localparam int EXP_KCLK_HI = 201;    // 200 inhibit cycles plus the REQ cycle
   localparam int EXP_TIMEOUT = 2000;   // 2 MHz / 1000 * 1 ms
   localparam int NV          = 5;

   typedef struct {
      logic [7:0]  data;
      bit          ack;
      bit          glitch;
      logic [10:0] frame;   // {stop, parity, data, start} as seen on the line
      bit          err;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready, busy, tx_done, tx_err;
   logic       kclk_oe, kdata_oe;
   logic       kclk_line, kdata_line;
   logic       dev_clk_low = 1'b0, dev_data_low = 1'b0, glitch_low = 1'b0;

   int n_vec = 0;
   int n_bad = 0;
   int kclk_hi_tot = 0, done_tot = 0, err_tot = 0, err_alone_tot = 0, ready_bad_tot = 0;
   logic prev_done = 1'b0;
   vec_t vecs[NV];

   always #5 clk = ~clk;

   assign kclk_line  = ~(kclk_oe | dev_clk_low | glitch_low);
   assign kdata_line = ~(kdata_oe | dev_data_low);

   ps2_host_tx #(
      .CLK_FREQUENCY_HZ (2_000_000),
      .INHIBIT_US       (100),
      .TIMEOUT_MS       (1),
      .FILTER_LEN       (8)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .busy     (busy),
      .tx_done  (tx_done),
      .tx_err   (tx_err),
      .kclk_in  (kclk_line),
      .kdata_in (kdata_line),
      .kclk_oe  (kclk_oe),
      .kdata_oe (kdata_oe)
   );

   always @(negedge clk) begin
      if (kclk_oe) kclk_hi_tot <= kclk_hi_tot + 1;
      if (tx_done) done_tot <= done_tot + 1;
      if (tx_err) err_tot <= err_tot + 1;
      if (tx_err && !tx_done) err_alone_tot <= err_alone_tot + 1;
      if (prev_done && !tx_ready) ready_bad_tot <= ready_bad_tot + 1;
      prev_done <= tx_done;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   // Device side: waits for the host request, then generates clock pulses. The line is
   // read before the first pulse (start) and at each rising edge; the acknowledge is
   // held low across the two clock pulses that follow the stop bit.
   task automatic device(input bit ack, input bit glitch, input int max_pulses,
                         output logic [10:0] bits);
      bit got;
      bits = '0;
      got  = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (kclk_line && !kdata_line) begin
            got = 1'b1;
            break;
         end
      end
      check("start_seen", 32'(got), 32'd1);
      if (!got) return;
      repeat (20) @(negedge clk);
      bits[0] = kdata_line;
      for (int p = 0; p < max_pulses; p++) begin
         dev_clk_low = 1'b1;
         repeat (HALF) @(negedge clk);
         if (p < 10) bits[p+1] = kdata_line;
         dev_clk_low = 1'b0;
         if (glitch && p < 10) begin
            repeat (15) @(negedge clk);
            glitch_low = 1'b1;
            repeat (4) @(negedge clk);
            glitch_low = 1'b0;
            repeat (HALF - 19) @(negedge clk);
         end else begin
            repeat (HALF) @(negedge clk);
         end
         if (p == 9 && ack) dev_data_low = 1'b1;
         if (p == 11) dev_data_low = 1'b0;
      end
   endtask

   task automatic do_transfer(input vec_t v, input string tag);
      logic [10:0] bits;
      int s_hi, s_done, s_err, s_alone, s_rdy;
      @(negedge clk);
      check({tag, "_ready_before"}, 32'(tx_ready), 32'd1);
      s_hi = kclk_hi_tot; s_done = done_tot; s_err = err_tot;
      s_alone = err_alone_tot; s_rdy = ready_bad_tot;
      tx_data  = v.data;
      tx_valid = 1'b1;
      @(negedge clk);
      check({tag, "_accept_kclk_oe"}, 32'(kclk_oe), 32'd1);
      check({tag, "_accept_busy"}, 32'(busy), 32'd1);
      tx_data = 8'h55;   // must be ignored while busy
      repeat (8) @(negedge clk);
      tx_valid = 1'b0;
      device(v.ack, v.glitch, 12, bits);
      for (int i = 0; i < 3000 && done_tot == s_done; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      check({tag, "_frame"}, 32'(bits), 32'(v.frame));
      check({tag, "_done_count"}, 32'(done_tot - s_done), 32'd1);
      check({tag, "_err_count"}, 32'(err_tot - s_err), 32'(v.err));
      check({tag, "_err_without_done"}, 32'(err_alone_tot - s_alone), 32'd0);
      check({tag, "_kclk_oe_cycles"}, 32'(kclk_hi_tot - s_hi), 32'(EXP_KCLK_HI));
      check({tag, "_ready_after_done"}, 32'(ready_bad_tot - s_rdy), 32'd0);
      check({tag, "_lines_released"}, {30'd0, kclk_oe, kdata_oe}, 32'd0);
   endtask

   initial begin
      logic [10:0] bits;
      int          n, s_done;
      bit          found;

      vecs[0] = '{data: 8'hED, ack: 1'b1, glitch: 1'b0, frame: {1'b1, 1'b1, 8'hED, 1'b0}, err: 1'b0};
      vecs[1] = '{data: 8'h01, ack: 1'b1, glitch: 1'b0, frame: {1'b1, 1'b0, 8'h01, 1'b0}, err: 1'b0};
      vecs[2] = '{data: 8'h00, ack: 1'b1, glitch: 1'b0, frame: {1'b1, 1'b1, 8'h00, 1'b0}, err: 1'b0};
      vecs[3] = '{data: 8'hA5, ack: 1'b0, glitch: 1'b0, frame: {1'b1, 1'b1, 8'hA5, 1'b0}, err: 1'b1};
      vecs[4] = '{data: 8'h3C, ack: 1'b1, glitch: 1'b1, frame: {1'b1, 1'b1, 8'h3C, 1'b0}, err: 1'b0};

      reset    = 1'b1;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_kclk_oe", 32'(kclk_oe), 32'd0);
      check("rst_kdata_oe", 32'(kdata_oe), 32'd0);
      check("rst_tx_ready", 32'(tx_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_tx_done", 32'(tx_done), 32'd0);
      check("rst_tx_err", 32'(tx_err), 32'd0);
      reset = 1'b0;

      for (int i = 0; i < NV; i++) do_transfer(vecs[i], $sformatf("v%0d", i));

      // Device never clocks: timeout counted from the first cycle with the clock released.
      @(negedge clk);
      tx_data  = 8'h12;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (!kclk_oe) begin
            found = 1'b1;
            break;
         end
      end
      check("tmo_clock_released", 32'(found), 32'd1);
      n = 0;
      for (int i = 0; i < 2500; i++) begin
         @(negedge clk);
         n++;
         if (tx_done) break;
      end
      check("tmo_cycles", 32'(n), 32'(EXP_TIMEOUT));
      check("tmo_err", 32'(tx_err), 32'd1);
      check("tmo_lines", {30'd0, kclk_oe, kdata_oe}, 32'd0);
      @(negedge clk);
      check("tmo_ready_after", 32'(tx_ready), 32'd1);

      // Reset while bit 4 of 0xFF is on the line.
      s_done   = done_tot;
      tx_data  = 8'hFF;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      device(1'b1, 1'b0, 5, bits);
      check("rst_mid_bits", 32'(bits[5:0]), 32'h3E);
      check("rst_mid_busy_before", 32'(busy), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      check("rst_mid_lines", {30'd0, kclk_oe, kdata_oe}, 32'd0);
      check("rst_mid_busy_after", 32'(busy), 32'd0);
      reset = 1'b0;
      repeat (2200) @(negedge clk);
      check("rst_mid_no_done", 32'(done_tot - s_done), 32'd0);

      do_transfer('{data: 8'hF3, ack: 1'b1, glitch: 1'b0,
                    frame: {1'b1, 1'b1, 8'hF3, 1'b0}, err: 1'b0}, "after_rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
